reg_serial_loader: RTL and testbench

//   Serial-to-parallel loader that sits directly upstream of a WIDTH-bit bank of REG1 cells.

---
 rtl/reg_serial_loader.sv | 99 +++++++++
 tb/tb_reg_serial_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_serial_loader.sv
// Serial-to-parallel loader feeding a WIDTH-bit bank of REG1 cells.
// Collects one bit per accepted handshake, publishes the finished word on D
// and pulses L for one cycle so the bank captures it.
module reg_serial_loader #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             C,
   input  logic             nR,
   input  logic             start,
   input  logic             abort,
   input  logic             sin,
   input  logic             sin_valid,
   output logic             sin_ready,
   output logic [WIDTH-1:0] D,
   output logic             L,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_next;
   logic [CW-1:0]    count;

   // Shift register contents after taking in the current sin bit; the
   // direction decides whether the first bit ends up at the top or bottom.
   always_comb begin
      sreg_next = sreg;
      if (MSB_FIRST) begin
         sreg_next = {sreg[WIDTH-2:0], sin};
      end else begin
         sreg_next = {sin, sreg[WIDTH-1:1]};
      end
   end

   // Frame sequencing: abort beats a same-cycle bit, and the last bit goes
   // straight into D so the word is already stable when L rises.
   always_ff @(posedge C or negedge nR) begin
      if (!nR) begin
         state <= IDLE;
         sreg  <= '0;
         count <= '0;
         D     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SHIFT;
                  sreg  <= '0;
                  count <= '0;
               end
            end
            SHIFT: begin
               if (abort) begin
                  state <= IDLE;
                  sreg  <= '0;
                  count <= '0;
               end else if (sin_valid) begin
                  sreg  <= sreg_next;
                  count <= count + CW'(1);
                  if (count == LAST) begin
                     D     <= sreg_next;
                     state <= LOAD;
                  end
               end
            end
            LOAD: begin
               if (start) begin
                  state <= SHIFT;
                  sreg  <= '0;
                  count <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake and strobe outputs come purely from the state register, so
   // they fall immediately when nR resets the state.
   always_comb begin
      sin_ready = (state == SHIFT);
      busy      = (state == SHIFT) || (state == LOAD);
      L         = (state == LOAD);
   end

endmodule

// File: tb/tb_reg_serial_loader.sv
// Bench for reg_serial_loader: two instances (MSB-first and LSB-first) share
// one stimulus stream and are compared each cycle against a frame-level model.
module tb_reg_serial_loader;

   localparam int W = 8;

   localparam int M_IDLE  = 0;
   localparam int M_SHIFT = 1;
   localparam int M_LOAD  = 2;

   logic C = 1'b0;
   logic nR = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic sin = 1'b0;
   logic sin_valid = 1'b0;

   logic         ready_m, l_m, busy_m;
   logic [W-1:0] d_m;
   logic         ready_l, l_l, busy_l;
   logic [W-1:0] d_l;

   int checks = 0;
   int errors = 0;

   int           mode = M_IDLE;
   bit           frame_bits[$];
   logic [W-1:0] exp_dm = '0;
   logic [W-1:0] exp_dl = '0;

   reg_serial_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .C(C), .nR(nR), .start(start), .abort(abort), .sin(sin),
      .sin_valid(sin_valid), .sin_ready(ready_m), .D(d_m), .L(l_m), .busy(busy_m)
   );

   reg_serial_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .C(C), .nR(nR), .start(start), .abort(abort), .sin(sin),
      .sin_valid(sin_valid), .sin_ready(ready_l), .D(d_l), .L(l_l), .busy(busy_l)
   );

   // Free-running clock.
   always #5 C = ~C;

   // Word built from the collected frame: bit i of the frame lands at
   // position W-1-i (MSB first) or position i (LSB first).
   function automatic logic [W-1:0] buildWord(input bit msb);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < W; i++) begin
         if (msb) w[W-1-i] = frame_bits[i];
         else     w[i]     = frame_bits[i];
      end
      return w;
   endfunction

   task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput(input string tag);
      check1({tag, "/D_msb"},     32'(d_m),     32'(exp_dm));
      check1({tag, "/L_msb"},     32'(l_m),     32'(mode == M_LOAD));
      check1({tag, "/ready_msb"}, 32'(ready_m), 32'(mode == M_SHIFT));
      check1({tag, "/busy_msb"},  32'(busy_m),  32'(mode != M_IDLE));
      check1({tag, "/D_lsb"},     32'(d_l),     32'(exp_dl));
      check1({tag, "/L_lsb"},     32'(l_l),     32'(mode == M_LOAD));
      check1({tag, "/ready_lsb"}, 32'(ready_l), 32'(mode == M_SHIFT));
      check1({tag, "/busy_lsb"},  32'(busy_l),  32'(mode != M_IDLE));
   endtask

   // One clock cycle: drive inputs, advance the model on the edge, check.
   task automatic applyStimulus(input logic st, input logic ab, input logic b,
                                input logic v, input string tag);
      start     = st;
      abort     = ab;
      sin       = b;
      sin_valid = v;
      @(posedge C);
      case (mode)
         M_IDLE: begin
            if (st) begin
               mode = M_SHIFT;
               frame_bits.delete();
            end
         end
         M_SHIFT: begin
            if (ab) begin
               mode = M_IDLE;
               frame_bits.delete();
            end else if (v) begin
               frame_bits.push_back(b);
               if (frame_bits.size() == W) begin
                  exp_dm = buildWord(1'b1);
                  exp_dl = buildWord(1'b0);
                  mode   = M_LOAD;
               end
            end
         end
         default: begin
            frame_bits.delete();
            mode = st ? M_SHIFT : M_IDLE;
         end
      endcase
      #1;
      checkOutput(tag);
   endtask

   // Asynchronous reset pulse taken between clock edges.
   task automatic asyncReset(input string tag);
      nR = 1'b0;
      #1;
      mode   = M_IDLE;
      frame_bits.delete();
      exp_dm = '0;
      exp_dl = '0;
      checkOutput(tag);
      @(negedge C);
      nR = 1'b1;
   endtask

   // Send W bits taken from v, most significant first, with an optional stall.
   task automatic sendBits(input logic [W-1:0] v, input int stall_at,
                           input int stall_len, input string tag);
      for (int i = 0; i < W; i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, tag);
         end
         applyStimulus(1'b0, 1'b0, v[W-1-i], 1'b1, tag);
      end
   endtask

   // Directed scenarios followed by a randomized soak.
   initial begin
      asyncReset("reset_at_start");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t2_start");
      sendBits(8'b1011_0010, -1, 0, "t2_bits");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "t2_after_load");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "t2_idle_ignores_valid");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t3_start");
      sendBits(8'b1011_0010, 4, 3, "t3_stalled");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t3_after_load");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t4_start");
      sendBits(8'b1000_0000, -1, 0, "t4_bits");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t4_after_load");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t5_prime_start");
      sendBits(8'b1011_0010, -1, 0, "t5_prime");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t5_prime_done");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t5_start_a");
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "t5_bits_a");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, "t5_abort_a");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t5_start_b");
      for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, "t5_bits_b");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, "t5_abort_on_last");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t5_stay_idle");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t6_start");
      sendBits(8'b1100_0011, -1, 0, "t6_first");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t6_restart_in_load");
      sendBits(8'h5A, -1, 0, "t6_second");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, "t6_done");

      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t7_start");
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, "t7_bits");
      #2;
      asyncReset("t7_mid_frame_reset");
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, "t7_restart");
      sendBits(8'h3C, -1, 0, "t7_full");
      #2;
      asyncReset("t7_reset_during_L");

      for (int n = 0; n < 400; n++) begin
         applyStimulus(($urandom % 4) == 0, ($urandom % 12) == 0,
                       1'($urandom), ($urandom % 4) != 0, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
